// File: rtl/testdrive_axi4_pkg.sv
// Shared AXI4 encodings, 4KB constant, ARSIZE helper and read-master state type.
// Used by the read master and its burst splitter.
package testdrive_axi4_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int AXI_4KB = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_FIN
  } rd_state_e;

  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/testdrive_axi4_burst_splitter.sv
// Combinational INCR burst sizing: len = min(remaining, max burst, beats to 4KB edge).
// Zero latency, no handshake; len is 0 when remaining is 0.
module testdrive_axi4_burst_splitter
  import testdrive_axi4_pkg::*;
#(
  parameter int C_ADDR_WIDTH  = 32,
  parameter int C_DATA_WIDTH  = 128,
  parameter int C_MAX_BURST   = 16,
  parameter int C_BEATS_WIDTH = 16
) (
  input  logic [C_ADDR_WIDTH-1:0]  addr_i,
  input  logic [C_BEATS_WIDTH-1:0] remaining_i,
  output logic [8:0]               len_o,
  output logic [C_ADDR_WIDTH-1:0]  next_addr_o
);

  localparam logic [2:0] SIZE = axi_size(C_DATA_WIDTH);
  localparam int LW = (C_BEATS_WIDTH > 13) ? C_BEATS_WIDTH : 13;

  logic [12:0]   bytes_to_4k;
  logic [12:0]   beats_to_4k;
  logic [LW-1:0] rem_w;
  logic [LW-1:0] cap_w;
  logic [LW-1:0] len_w;

  always_comb begin
    bytes_to_4k = 13'(AXI_4KB) - {1'b0, addr_i[11:0]};
    beats_to_4k = bytes_to_4k >> SIZE;
    rem_w       = LW'(remaining_i);
    cap_w       = (beats_to_4k < 13'(C_MAX_BURST)) ? LW'(beats_to_4k) : LW'(C_MAX_BURST);
    len_w       = (rem_w < cap_w) ? rem_w : cap_w;
    // The cap never exceeds 256, so the length always fits in 9 bits.
    len_o       = 9'(len_w);
    next_addr_o = addr_i + (C_ADDR_WIDTH'(len_o) << SIZE);
  end

endmodule

// File: rtl/testdrive_axi4_read_master.sv
// AXI4 read initiator: splits a linear read command into INCR bursts, one outstanding.
// R data passes through to OUT_* with zero latency; RREADY follows OUT_READY in DATA.
module testdrive_axi4_read_master
  import testdrive_axi4_pkg::*;
#(
  parameter int C_THREAD_ID_WIDTH = 1,
  parameter int C_ADDR_WIDTH      = 32,
  parameter int C_DATA_WIDTH      = 128,
  parameter int C_MAX_BURST       = 16,
  parameter int C_BEATS_WIDTH     = 16,
  parameter int C_ARID            = 0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         CMD_VALID,
  output logic                         CMD_READY,
  input  logic [C_ADDR_WIDTH-1:0]      CMD_ADDR,
  input  logic [C_BEATS_WIDTH-1:0]     CMD_BEATS,
  output logic [C_THREAD_ID_WIDTH-1:0] ARID,
  output logic [C_ADDR_WIDTH-1:0]      ARADDR,
  output logic [7:0]                   ARLEN,
  output logic [2:0]                   ARSIZE,
  output logic [1:0]                   ARBURST,
  output logic                         ARLOCK,
  output logic [3:0]                   ARCACHE,
  output logic [2:0]                   ARPROT,
  output logic [3:0]                   ARREGION,
  output logic [3:0]                   ARQOS,
  output logic                         ARVALID,
  input  logic                         ARREADY,
  input  logic [C_THREAD_ID_WIDTH-1:0] RID,
  input  logic [C_DATA_WIDTH-1:0]      RDATA,
  input  logic [1:0]                   RRESP,
  input  logic                         RLAST,
  input  logic                         RVALID,
  output logic                         RREADY,
  output logic [C_DATA_WIDTH-1:0]      OUT_DATA,
  output logic                         OUT_LAST,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic                         DONE,
  output logic                         DONE_ERR
);

  localparam logic [2:0] SIZE = axi_size(C_DATA_WIDTH);

  rd_state_e                state_q, state_d;
  logic [C_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [C_BEATS_WIDTH-1:0] rem_q, rem_d;
  logic [C_ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic [7:0]               arlen_q, arlen_d;
  logic                     arvalid_q, arvalid_d;
  logic [8:0]               cnt_q, cnt_d;
  logic [8:0]               exp_q, exp_d;
  logic                     err_q, err_d;
  logic                     done_q, done_d;
  logic                     done_err_q, done_err_d;
  logic                     cmd_rdy_q, cmd_rdy_d;

  logic [C_ADDR_WIDTH-1:0]  cmd_addr_al;
  logic [C_ADDR_WIDTH-1:0]  split_addr;
  logic [C_BEATS_WIDTH-1:0] split_rem;
  logic [8:0]               split_len;
  logic [C_ADDR_WIDTH-1:0]  split_next;
  logic                     r_beat;
  logic                     last_cnt;
  logic                     load_burst;

  assign cmd_addr_al = (CMD_ADDR >> SIZE) << SIZE;
  assign split_addr  = (state_q == ST_IDLE) ? cmd_addr_al : addr_q;
  assign split_rem   = (state_q == ST_IDLE) ? CMD_BEATS : rem_q;

  testdrive_axi4_burst_splitter #(
    .C_ADDR_WIDTH (C_ADDR_WIDTH),
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .C_MAX_BURST  (C_MAX_BURST),
    .C_BEATS_WIDTH(C_BEATS_WIDTH)
  ) u_split (
    .addr_i     (split_addr),
    .remaining_i(split_rem),
    .len_o      (split_len),
    .next_addr_o(split_next)
  );

  assign r_beat   = (state_q == ST_DATA) && RVALID && OUT_READY;
  assign last_cnt = (cnt_q == exp_q - 9'd1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arvalid_d  = arvalid_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    err_d      = err_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    load_burst = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID && cmd_rdy_q) begin
          if (CMD_BEATS == '0) state_d = ST_FIN;
          else                 load_burst = 1'b1;
        end
      end
      ST_ADDR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_beat) begin
          cnt_d = cnt_q + 9'd1;
          // RLAST disagreeing with the beat count flags both early and missing RLAST.
          if (RRESP != AXI_RESP_OKAY || RID != C_THREAD_ID_WIDTH'(C_ARID) || RLAST != last_cnt)
            err_d = 1'b1;
          if (RLAST || last_cnt) begin
            if (rem_q == '0) state_d = ST_FIN;
            else             load_burst = 1'b1;
          end
        end
      end
      ST_FIN: begin
        done_d     = 1'b1;
        done_err_d = err_q;
        err_d      = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_burst) begin
      state_d   = ST_ADDR;
      araddr_d  = split_addr;
      arlen_d   = 8'(split_len - 9'd1);
      arvalid_d = 1'b1;
      addr_d    = split_next;
      rem_d     = split_rem - C_BEATS_WIDTH'(split_len);
      exp_d     = split_len;
      cnt_d     = 9'd0;
    end
    cmd_rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arvalid_q  <= 1'b0;
      cnt_q      <= '0;
      exp_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      cmd_rdy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arvalid_q  <= arvalid_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
      cmd_rdy_q  <= cmd_rdy_d;
    end
  end

  assign CMD_READY = cmd_rdy_q;
  assign ARID      = C_THREAD_ID_WIDTH'(C_ARID);
  assign ARADDR    = araddr_q;
  assign ARLEN     = arlen_q;
  assign ARSIZE    = SIZE;
  assign ARBURST   = AXI_BURST_INCR;
  assign ARLOCK    = 1'b0;
  assign ARCACHE   = 4'b0011;
  assign ARPROT    = 3'b000;
  assign ARREGION  = 4'b0000;
  assign ARQOS     = 4'b0000;
  assign ARVALID   = arvalid_q;
  assign RREADY    = (state_q == ST_DATA) && OUT_READY;
  assign OUT_VALID = (state_q == ST_DATA) && RVALID;
  assign OUT_DATA  = RDATA;
  assign OUT_LAST  = (state_q == ST_DATA) && RLAST && (rem_q == '0);
  assign DONE      = done_q;
  assign DONE_ERR  = done_err_q;

endmodule

// File: tb/tb_testdrive_axi4_read_master.sv
// Randomized bench for the AXI4 read master: AXI responder, stream sink and a
// command-level reference model of burst splitting and expected output beats.
module tb_testdrive_axi4_read_master;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [31:0]  cmd_addr;
  logic [15:0]  cmd_beats;
  logic [0:0]   arid, rid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst, rresp;
  logic         arlock, arvalid, arready;
  logic [3:0]   arcache, arregion, arqos;
  logic [127:0] rdata, out_data;
  logic         rlast, rvalid, rready;
  logic         out_last, out_valid, out_ready;
  logic         done, done_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int done_base = 0;
  int acc_cyc = 0;
  int err_beat = -1;
  int cmd_beat_idx = 0;
  int out_mode = 0;
  logic slave_rand = 1'b0;
  logic exp_err = 1'b0;

  ar_t   exp_ar[$];
  beat_t exp_beat[$];
  ar_t   sq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  testdrive_axi4_read_master dut (
    .CLK(clk), .RST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_ADDR(cmd_addr), .CMD_BEATS(cmd_beats),
    .ARID(arid), .ARADDR(araddr), .ARLEN(arlen), .ARSIZE(arsize), .ARBURST(arburst),
    .ARLOCK(arlock), .ARCACHE(arcache), .ARPROT(arprot), .ARREGION(arregion), .ARQOS(arqos),
    .ARVALID(arvalid), .ARREADY(arready),
    .RID(rid), .RDATA(rdata), .RRESP(rresp), .RLAST(rlast), .RVALID(rvalid), .RREADY(rready),
    .OUT_DATA(out_data), .OUT_LAST(out_last), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .DONE(done), .DONE_ERR(done_err)
  );

  function automatic logic [127:0] beat_data(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5a5a_5a5a, a + 32'd7};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI responder: accepts AR, returns one burst at a time with optional gaps.
  initial begin
    logic ar_fire, r_fire;
    ar_t  s_ar;
    int   bib;
    bib = 0;
    arready = 0; rvalid = 0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 0;
    forever begin
      @(negedge clk);
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      s_ar.addr = araddr;
      s_ar.len  = arlen;
      @(posedge clk); #1;
      if (rst) begin
        sq.delete(); bib = 0; rvalid = 0; arready = 0; rlast = 0;
      end else begin
        if (ar_fire) sq.push_back(s_ar);
        if (r_fire) begin
          cmd_beat_idx++;
          if (bib == int'(sq[0].len)) begin
            void'(sq.pop_front());
            bib = 0;
          end else bib++;
        end
        arready = slave_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (!(rvalid && !r_fire))
          rvalid = (sq.size() != 0) && (slave_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        if (sq.size() != 0) begin
          rdata = beat_data(sq[0].addr + 32'(bib * 16));
          rlast = (bib == int'(sq[0].len));
          rresp = (cmd_beat_idx == err_beat) ? 2'b10 : 2'b00;
        end else begin
          rlast = 0; rresp = 2'b00;
        end
      end
    end
  end

  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (out_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitors sample at the falling edge, where inputs are settled for the next rising edge.
  initial forever begin
    @(negedge clk);
    if (arvalid && arready) begin
      if (exp_ar.size() == 0) chk("ar_unexpected", 1'b1, 1'b0);
      else begin
        chk("ar_addr", araddr, exp_ar[0].addr);
        chk("ar_len", arlen, exp_ar[0].len);
        void'(exp_ar.pop_front());
      end
      chk("ar_const", {arid, arsize, arburst, arlock, arcache, arprot, arregion, arqos},
          {1'b0, 3'd4, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 4'b0000});
    end
    if (out_valid) chk("rready_mirror", rready, out_ready);
    if (out_valid && out_ready) begin
      if (exp_beat.size() == 0) chk("beat_unexpected", 1'b1, 1'b0);
      else begin
        chk("out_data", out_data, exp_beat[0].data);
        chk("out_last", out_last, exp_beat[0].last);
        void'(exp_beat.pop_front());
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_err", done_err, exp_err);
    end
  end

  task automatic start_cmd(input logic [31:0] a, input int beats, input int eb);
    logic [31:0] ad;
    int rem, len, b4k;
    logic acc;
    ad = a & ~32'hF;
    rem = beats;
    exp_err = (eb >= 0) && (eb < beats);
    err_beat = eb;
    cmd_beat_idx = 0;
    while (rem > 0) begin
      b4k = (4096 - int'(ad % 4096)) / 16;
      len = rem;
      if (len > 16) len = 16;
      if (len > b4k) len = b4k;
      exp_ar.push_back('{addr: ad, len: 8'(len - 1)});
      for (int i = 0; i < len; i++)
        exp_beat.push_back('{data: beat_data(ad + 32'(i * 16)), last: (rem == len) && (i == len - 1)});
      ad += 32'(len * 16);
      rem -= len;
    end
    done_base = done_cnt;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_addr = a; cmd_beats = 16'(beats);
    acc = 0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = 1; acc_cyc = cyc; end
    end
    chk("cmd_accept", acc, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic finish_cmd(input string tag);
    int n;
    n = 0;
    while (done_cnt == done_base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt != done_base, 1'b1);
    repeat (4) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt - done_base, 1);
    chk({tag, "_ar_left"}, exp_ar.size(), 0);
    chk({tag, "_beats_left"}, exp_beat.size(), 0);
  endtask

  initial begin
    logic hit;
    rst = 1; cmd_valid = 0; cmd_addr = '0; cmd_beats = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_outputs", {arvalid, cmd_ready, done, done_err, rready, out_valid}, 6'b0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_arlen", arlen, 8'h0);
    @(posedge clk); #1 rst = 0;

    start_cmd(32'h0000_1000, 16, -1);  finish_cmd("single");
    start_cmd(32'h0000_0FC0, 10, -1);  finish_cmd("cross4k");
    out_mode = 1;
    start_cmd(32'h0000_2000, 40, -1);  finish_cmd("toggle");
    out_mode = 0;
    start_cmd(32'h0000_0000, 0, -1);   finish_cmd("zero");
    chk("zero_done_latency", done_cyc - acc_cyc, 2);
    start_cmd(32'h0000_5000, 8, 2);    finish_cmd("slverr");
    start_cmd(32'h0000_6008, 8, -1);   finish_cmd("after_err");

    slave_rand = 1; out_mode = 2;
    start_cmd(32'h0000_3000, 48, -1);
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (out_valid && exp_beat.size() < 40) hit = 1;
    end
    chk("rst_reach_data", hit, 1'b1);
    #1 rst = 1;
    #1;
    chk("midrst_low", {arvalid, rready, out_valid, done, cmd_ready}, 5'b0);
    chk("midrst_araddr", araddr, 32'h0);
    exp_ar.delete();
    exp_beat.delete();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt - done_base, 0);
    start_cmd(32'h0000_7F80, 20, -1);  finish_cmd("post_rst");

    for (int k = 0; k < 8; k++) begin
      logic [31:0] a;
      int nb, eb;
      a  = 32'((($urandom_range(1, 7)) << 12) - ($urandom_range(0, 40) << 4) + $urandom_range(0, 15));
      nb = $urandom_range(1, 60);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
      start_cmd(a, nb, eb);
      finish_cmd("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/testdrive_axi4_read_master.md
Name: testdrive_axi4_read_master

Overview:
Synthesizable AXI4 read initiator, the requester-side counterpart to the AXI4 responder BFM. It accepts a linear read command (start address, beat count) and splits it into INCR bursts that respect C_MAX_BURST and 4KB boundaries. Returned R data goes to a valid/ready stream. It sits between DMA/test logic and an AXI4 slave, and is verified against the DPI-backed responder.

Parameters:
C_THREAD_ID_WIDTH, 1, width of ARID/RID
C_ADDR_WIDTH, 32, address width
C_DATA_WIDTH, 128, data width; power of 2, 8..1024
C_MAX_BURST, 16, max beats per burst, 1..256
C_BEATS_WIDTH, 16, width of command beat count
C_ARID, 0, constant ARID driven on every burst

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active high
CMD_VALID  in  1  command valid
CMD_READY  out  1  command accepted when CMD_VALID&CMD_READY
CMD_ADDR  in  C_ADDR_WIDTH  start byte address; low log2(C_DATA_WIDTH/8) bits forced to 0
CMD_BEATS  in  C_BEATS_WIDTH  total full-width beats
ARID  out  C_THREAD_ID_WIDTH  =C_ARID
ARADDR  out  C_ADDR_WIDTH  burst address
ARLEN  out  8  beats-1
ARSIZE  out  3  log2(C_DATA_WIDTH/8), constant
ARBURST  out  2  2'b01 INCR, constant
ARLOCK/ARCACHE/ARPROT/ARREGION/ARQOS  out  1/4/3/4/4  0 / 4'b0011 / 0 / 0 / 0, constant
ARVALID  out  1  address valid
ARREADY  in  1  address ready
RID  in  C_THREAD_ID_WIDTH  read ID
RDATA  in  C_DATA_WIDTH  read data
RRESP  in  2  read response
RLAST  in  1  last beat of burst
RVALID  in  1  read valid
RREADY  out  1  read ready
OUT_DATA  out  C_DATA_WIDTH  =RDATA
OUT_LAST  out  1  final beat of the whole command
OUT_VALID  out  1  stream valid
OUT_READY  in  1  stream ready
DONE  out  1  one-cycle pulse at command completion
DONE_ERR  out  1  valid with DONE; 1 if any error occurred in the command

Behaviour:
- Reset (async, RST=1): state IDLE; ARVALID=0, CMD_READY=0, DONE=0, DONE_ERR=0, ARADDR=0, ARLEN=0; RREADY/OUT_VALID=0 because they are gated by state. All counters are cleared. Reset mid-burst abandons the transfer with no DONE.
- FSM IDLE/ADDR/DATA/FIN:
  - IDLE: CMD_READY=1. On accept, latch the aligned addr and remaining=CMD_BEATS. If CMD_BEATS==0, go to FIN; otherwise go to ADDR.
  - ADDR: ARVALID=1 (registered). Stable until ARREADY; then go to DATA.
  - DATA: RREADY=OUT_READY and OUT_VALID=RVALID, combinational pass-through with zero latency. Each beat transfers on RVALID&RREADY. On the beat with RLAST, or when the expected count is reached: if remaining==0, go to FIN; else go to ADDR with the next address.
  - FIN: DONE=1 for one cycle, DONE_ERR=sticky err, then go to IDLE and clear err.
- Burst length on ADDR entry: len = min(remaining, C_MAX_BURST, beats_to_4k), where beats_to_4k = (4096 - addr[11:0]) >> ARSIZE. ARLEN=len-1 and remaining -= len; next addr = addr + (len << ARSIZE).
- Only one burst is outstanding; no new AR is issued until the current burst's data completes.
- OUT_LAST = RLAST && remaining==0 && state==DATA.
- Errors set the sticky err flag without stalling:
  - RRESP!=0 on any beat.
  - RID!=C_ARID.
  - RLAST early, before the expected count. The burst is treated as ended and the missing beats are not re-requested.
  - RLAST missing on the expected final beat. The burst is treated as ended at the count; any further R beats in IDLE are ignored with RREADY=0.
- An RVALID seen outside DATA is not accepted.

Decomposition:
- Package testdrive_axi4_pkg: AXI_BURST_FIXED/INCR/WRAP, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, AXI_4KB=4096, function axi_size(data_width) returning the ARSIZE encoding, and the state enum typedef.
- Sub-module testdrive_axi4_burst_splitter: combinational len/next-address calculation from (addr, remaining), reusable by a future write master.

Test Plan:
- C_DATA_WIDTH=128, CMD_ADDR=0x1000, CMD_BEATS=16, slave ready always -> one AR: ARADDR=0x1000, ARLEN=15, ARSIZE=4. 16 OUT beats, OUT_LAST on the 16th, DONE=1 with DONE_ERR=0.
- CMD_ADDR=0x0FC0, CMD_BEATS=10 -> AR0 0x0FC0 ARLEN=3, AR1 0x1000 ARLEN=5. OUT_LAST only on beat 10.
- CMD_ADDR=0x2000, CMD_BEATS=40, C_MAX_BURST=16 -> ARLEN 15,15,7 at 0x2000, 0x2100, 0x2200. OUT_READY toggling 1/0 each cycle -> RREADY mirrors it, no data lost, 40 beats delivered.
- CMD_BEATS=0 -> no ARVALID, DONE pulse two cycles after accept, DONE_ERR=0.
- RRESP=2'b10 on beat 3 of 8 -> all 8 beats forwarded, DONE_ERR=1. The next command completes with DONE_ERR=0.
- Assert RST while in DATA with ARVALID history -> RREADY, OUT_VALID, and ARVALID low in the same cycle, no DONE. A new command after release runs normally.
